ex_mem_stage_reg: RTL and testbench

- Parametrised EX→MEM pipeline register for the MIPS datapath; replaces the fixed-width, always-loading EX/MEM buffer.
- Adds a synchronous reset, stall (hold), flush (bubble insertion), a per-stage valid bit and registered branch-resolution outputs.
- Adds saturating bubble and stall performance counters.
- Sits between the ALU/EX stage and data memory; its outputs drive data memory, the PC-source mux and the MEM/WB register.

---
 rtl/ex_mem_stage_reg_if.sv | 64 ++++++
 rtl/ex_mem_stage_reg.sv | 128 ++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_reg_if.sv
// ex_mem_stage_reg_if
//   Bundles every EX->MEM stage signal except clock and reset.
//   master : EX-side driver. Drives stall/flush, the instruction fields and
//            the control bits, and observes the registered stage outputs.
//   slave  : the stage register itself.
//   Inputs : stall, flush, in_valid, pc_adder, zero_flag, alu_result,
//            data_write, reg_dst, branch, mem_write, mem_read, reg_write,
//            mem_to_reg
//   Outputs: out_* registered copies, out_valid, branch_taken,
//            bubble_cnt, stall_cnt
interface ex_mem_stage_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  stall;
  logic                  flush;
  logic                  in_valid;
  logic [DATA_W-1:0]     pc_adder;
  logic                  zero_flag;
  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     data_write;
  logic [REG_ADDR_W-1:0] reg_dst;
  logic                  branch;
  logic                  mem_write;
  logic                  mem_read;
  logic                  reg_write;
  logic                  mem_to_reg;

  logic [DATA_W-1:0]     out_pc_adder;
  logic [DATA_W-1:0]     out_alu_result;
  logic [DATA_W-1:0]     out_data_write;
  logic                  out_zero_flag;
  logic [REG_ADDR_W-1:0] out_reg_dst;
  logic                  out_branch;
  logic                  out_mem_write;
  logic                  out_mem_read;
  logic                  out_reg_write;
  logic                  out_mem_to_reg;
  logic                  out_valid;
  logic                  branch_taken;
  logic [CNT_W-1:0]      bubble_cnt;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output stall, flush, in_valid, pc_adder, zero_flag, alu_result,
           data_write, reg_dst, branch, mem_write, mem_read, reg_write,
           mem_to_reg,
    input  out_pc_adder, out_alu_result, out_data_write, out_zero_flag,
           out_reg_dst, out_branch, out_mem_write, out_mem_read,
           out_reg_write, out_mem_to_reg, out_valid, branch_taken,
           bubble_cnt, stall_cnt
  );

  modport slave (
    input  stall, flush, in_valid, pc_adder, zero_flag, alu_result,
           data_write, reg_dst, branch, mem_write, mem_read, reg_write,
           mem_to_reg,
    output out_pc_adder, out_alu_result, out_data_write, out_zero_flag,
           out_reg_dst, out_branch, out_mem_write, out_mem_read,
           out_reg_write, out_mem_to_reg, out_valid, branch_taken,
           bubble_cnt, stall_cnt
  );
endinterface

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg
//   EX->MEM pipeline register with stall (hold), flush (bubble), a valid bit,
//   registered branch resolution and saturating bubble/stall counters.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, overrides stall and flush
//   bus : ex_mem_stage_reg_if.slave carrying all stage inputs and outputs
//   Edge priority when not in reset: flush > stall > load.
module ex_mem_stage_reg #(
  parameter int DATA_W          = 32,
  parameter int REG_ADDR_W      = 5,
  parameter int CNT_W           = 16,
  parameter bit FLUSH_ZERO_DATA = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  ex_mem_stage_reg_if.slave  bus
);

  logic [DATA_W-1:0]     pcQ;
  logic [DATA_W-1:0]     aluQ;
  logic [DATA_W-1:0]     writeDataQ;
  logic [REG_ADDR_W-1:0] regDstQ;
  logic                  zeroQ;
  logic                  validQ;
  logic                  branchQ;
  logic                  memWriteQ;
  logic                  memReadQ;
  logic                  regWriteQ;
  logic                  memToRegQ;
  logic [CNT_W-1:0]      bubbleCnt;
  logic [CNT_W-1:0]      stallCnt;
  logic                  bubbleInc;
  logic                  stallInc;

  // Stage contents. Control bits are gated by in_valid on load so an
  // invalid slot can never write memory or the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcQ        <= '0;
      aluQ       <= '0;
      writeDataQ <= '0;
      regDstQ    <= '0;
      zeroQ      <= 1'b0;
      validQ     <= 1'b0;
      branchQ    <= 1'b0;
      memWriteQ  <= 1'b0;
      memReadQ   <= 1'b0;
      regWriteQ  <= 1'b0;
      memToRegQ  <= 1'b0;
    end else if (bus.flush) begin
      zeroQ     <= 1'b0;
      validQ    <= 1'b0;
      branchQ   <= 1'b0;
      memWriteQ <= 1'b0;
      memReadQ  <= 1'b0;
      regWriteQ <= 1'b0;
      memToRegQ <= 1'b0;
      if (FLUSH_ZERO_DATA) begin
        pcQ        <= '0;
        aluQ       <= '0;
        writeDataQ <= '0;
        regDstQ    <= '0;
      end else begin
        pcQ        <= bus.pc_adder;
        aluQ       <= bus.alu_result;
        writeDataQ <= bus.data_write;
        regDstQ    <= bus.reg_dst;
      end
    end else if (!bus.stall) begin
      pcQ        <= bus.pc_adder;
      aluQ       <= bus.alu_result;
      writeDataQ <= bus.data_write;
      regDstQ    <= bus.reg_dst;
      zeroQ      <= bus.zero_flag;
      validQ     <= bus.in_valid;
      branchQ    <= bus.branch     & bus.in_valid;
      memWriteQ  <= bus.mem_write  & bus.in_valid;
      memReadQ   <= bus.mem_read   & bus.in_valid;
      regWriteQ  <= bus.reg_write  & bus.in_valid;
      memToRegQ  <= bus.mem_to_reg & bus.in_valid;
    end
  end

  // A bubble is either a flush or a load of an invalid slot; a stall only
  // counts when no flush overrides it, so at most one counter moves per edge.
  always_comb begin
    bubbleInc = 1'b0;
    stallInc  = 1'b0;
    if (bus.flush) begin
      bubbleInc = 1'b1;
    end else if (bus.stall) begin
      stallInc = 1'b1;
    end else if (!bus.in_valid) begin
      bubbleInc = 1'b1;
    end
  end

  // Performance counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubbleCnt <= '0;
      stallCnt  <= '0;
    end else begin
      if (bubbleInc && (bubbleCnt != {CNT_W{1'b1}})) begin
        bubbleCnt <= bubbleCnt + 1'b1;
      end
      if (stallInc && (stallCnt != {CNT_W{1'b1}})) begin
        stallCnt <= stallCnt + 1'b1;
      end
    end
  end

  assign bus.out_pc_adder   = pcQ;
  assign bus.out_alu_result = aluQ;
  assign bus.out_data_write = writeDataQ;
  assign bus.out_reg_dst    = regDstQ;
  assign bus.out_zero_flag  = zeroQ;
  assign bus.out_valid      = validQ;
  assign bus.out_branch     = branchQ;
  assign bus.out_mem_write  = memWriteQ;
  assign bus.out_mem_read   = memReadQ;
  assign bus.out_reg_write  = regWriteQ;
  assign bus.out_mem_to_reg = memToRegQ;
  assign bus.branch_taken   = validQ & branchQ & zeroQ;
  assign bus.bubble_cnt     = bubbleCnt;
  assign bus.stall_cnt      = stallCnt;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb_ex_mem_stage_reg
//   Drives two stage registers with identical stimulus:
//     dutA : FLUSH_ZERO_DATA=0, CNT_W=16
//     dutB : FLUSH_ZERO_DATA=1, CNT_W=3 (exercises counter saturation)
//   Each driven cycle queues its hand-computed expected stage contents; an
//   independent monitor pops one entry per clock and compares both DUTs.
module tb_ex_mem_stage_reg;

  typedef struct {
    string       tag;
    logic        valid;
    logic [4:0]  ctl;
    logic        zero;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dw;
    logic [4:0]  rd;
    int          bubbles;
    int          stalls;
    logic        zeroDataB;
  } expT;

  logic clk;
  logic rst;
  expT  sb[$];
  expT  cur;
  int   checks;
  int   failures;
  int   expBubbles;
  int   expStalls;

  ex_mem_stage_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) busA();
  ex_mem_stage_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(3))  busB();

  ex_mem_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16), .FLUSH_ZERO_DATA(1'b0)) dutA (
    .clk(clk),
    .rst(rst),
    .bus(busA.slave)
  );

  ex_mem_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(3), .FLUSH_ZERO_DATA(1'b1)) dutB (
    .clk(clk),
    .rst(rst),
    .bus(busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; 4-state compare so X outputs are caught.
  task automatic compare(input string tag, input string name,
                         input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h", tag, name, act, req);
    end
  endtask

  task automatic checkOutput(input expT e);
    logic [2:0] satB;
    logic [31:0] pcB, aluB, dwB;
    logic [4:0] rdB;
    satB = (e.stalls > 7) ? 3'd7 : 3'(e.stalls);
    pcB  = e.zeroDataB ? 32'h0 : e.pc;
    aluB = e.zeroDataB ? 32'h0 : e.alu;
    dwB  = e.zeroDataB ? 32'h0 : e.dw;
    rdB  = e.zeroDataB ? 5'h0 : e.rd;
    compare(e.tag, "A.valid", 32'(busA.out_valid), 32'(e.valid));
    compare(e.tag, "A.ctl", 32'({busA.out_branch, busA.out_mem_write, busA.out_mem_read,
                                 busA.out_reg_write, busA.out_mem_to_reg}), 32'(e.ctl));
    compare(e.tag, "A.zero", 32'(busA.out_zero_flag), 32'(e.zero));
    compare(e.tag, "A.taken", 32'(busA.branch_taken), 32'(e.taken));
    compare(e.tag, "A.pc", busA.out_pc_adder, e.pc);
    compare(e.tag, "A.alu", busA.out_alu_result, e.alu);
    compare(e.tag, "A.dw", busA.out_data_write, e.dw);
    compare(e.tag, "A.rd", 32'(busA.out_reg_dst), 32'(e.rd));
    compare(e.tag, "A.bubbleCnt", 32'(busA.bubble_cnt), 32'(e.bubbles));
    compare(e.tag, "A.stallCnt", 32'(busA.stall_cnt), 32'(e.stalls));
    compare(e.tag, "B.valid", 32'(busB.out_valid), 32'(e.valid));
    compare(e.tag, "B.ctl", 32'({busB.out_branch, busB.out_mem_write, busB.out_mem_read,
                                 busB.out_reg_write, busB.out_mem_to_reg}), 32'(e.ctl));
    compare(e.tag, "B.taken", 32'(busB.branch_taken), 32'(e.taken));
    compare(e.tag, "B.pc", busB.out_pc_adder, pcB);
    compare(e.tag, "B.alu", busB.out_alu_result, aluB);
    compare(e.tag, "B.dw", busB.out_data_write, dwB);
    compare(e.tag, "B.rd", 32'(busB.out_reg_dst), 32'(rdB));
    compare(e.tag, "B.bubbleCnt", 32'(busB.bubble_cnt), 32'(e.bubbles));
    compare(e.tag, "B.stallCnt", 32'(busB.stall_cnt), 32'(satB));
  endtask

  // Monitor: one expected entry per clock edge, sampled 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      checkOutput(cur);
    end
  end

  // Drives both DUTs identically on the falling edge.
  // ctl packing: {branch, mem_write, mem_read, reg_write, mem_to_reg}
  task automatic applyStimulus(input logic r, input logic s, input logic f, input logic v,
                               input logic [4:0] ctl, input logic z, input logic [31:0] pc,
                               input logic [31:0] alu, input logic [31:0] dw,
                               input logic [4:0] rd);
    @(negedge clk);
    rst = r;
    busA.stall = s;        busB.stall = s;
    busA.flush = f;        busB.flush = f;
    busA.in_valid = v;     busB.in_valid = v;
    busA.branch = ctl[4];  busB.branch = ctl[4];
    busA.mem_write = ctl[3]; busB.mem_write = ctl[3];
    busA.mem_read = ctl[2];  busB.mem_read = ctl[2];
    busA.reg_write = ctl[1]; busB.reg_write = ctl[1];
    busA.mem_to_reg = ctl[0]; busB.mem_to_reg = ctl[0];
    busA.zero_flag = z;    busB.zero_flag = z;
    busA.pc_adder = pc;    busB.pc_adder = pc;
    busA.alu_result = alu; busB.alu_result = alu;
    busA.data_write = dw;  busB.data_write = dw;
    busA.reg_dst = rd;     busB.reg_dst = rd;
  endtask

  // Queues the stage contents expected after the upcoming rising edge.
  task automatic expectOut(input string tag, input logic valid, input logic [4:0] ctl,
                           input logic zero, input logic taken, input logic [31:0] pc,
                           input logic [31:0] alu, input logic [31:0] dw,
                           input logic [4:0] rd, input logic zeroDataB);
    expT e;
    e.tag = tag;
    e.valid = valid;
    e.ctl = ctl;
    e.zero = zero;
    e.taken = taken;
    e.pc = pc;
    e.alu = alu;
    e.dw = dw;
    e.rd = rd;
    e.bubbles = expBubbles;
    e.stalls = expStalls;
    e.zeroDataB = zeroDataB;
    sb.push_back(e);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    expBubbles = 0;
    expStalls = 0;
    rst = 1'b1;

    // Reset with every input nonzero, held for two edges.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 1, 5'b11111, 1, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_BABE, 5'd31);
      expectOut("reset", 0, 5'b00000, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    end

    // Load something, then reset together with stall and flush.
    applyStimulus(0, 0, 0, 1, 5'b11111, 1, 32'h100, 32'h55, 32'h66, 5'd3);
    expectOut("preload", 1, 5'b11111, 1, 1, 32'h100, 32'h55, 32'h66, 5'd3, 0);
    applyStimulus(1, 1, 1, 1, 5'b11111, 1, 32'h100, 32'h55, 32'h66, 5'd3);
    expectOut("resetStallFlush", 0, 5'b00000, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0);

    // Pass-through of a register-writing instruction.
    applyStimulus(0, 0, 0, 1, 5'b00010, 0, 32'h0, 32'h0000_00A4, 32'h0, 5'd9);
    expectOut("passThrough", 1, 5'b00010, 0, 0, 32'h0, 32'hA4, 32'h0, 5'd9, 0);

    // Taken branch, then the same branch in an invalid slot.
    applyStimulus(0, 0, 0, 1, 5'b10000, 1, 32'h0040_0020, 32'h0, 32'h0, 5'd0);
    expectOut("branchTaken", 1, 5'b10000, 1, 1, 32'h0040_0020, 32'h0, 32'h0, 5'd0, 0);
    applyStimulus(0, 0, 0, 0, 5'b10000, 1, 32'h0040_0020, 32'h0, 32'h0, 5'd0);
    expBubbles = 1;
    expectOut("branchInvalid", 0, 5'b00000, 1, 0, 32'h0040_0020, 32'h0, 32'h0, 5'd0, 0);

    // Stall holds 0x11 for three cycles while inputs move to 0x22.
    applyStimulus(0, 0, 0, 1, 5'b00010, 0, 32'h0, 32'h11, 32'h0, 5'd4);
    expectOut("stallLoad", 1, 5'b00010, 0, 0, 32'h0, 32'h11, 32'h0, 5'd4, 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 0, 1, 5'b00010, 0, 32'h0, 32'h22, 32'h0, 5'd7);
      expStalls = i;
      expectOut("stallHold", 1, 5'b00010, 0, 0, 32'h0, 32'h11, 32'h0, 5'd4, 0);
    end
    applyStimulus(0, 0, 0, 1, 5'b00010, 0, 32'h0, 32'h22, 32'h0, 5'd7);
    expectOut("stallRelease", 1, 5'b00010, 0, 0, 32'h0, 32'h22, 32'h0, 5'd7, 0);

    // Flush and stall together with a store: flush wins.
    applyStimulus(0, 1, 1, 1, 5'b01000, 1, 32'h88, 32'h77, 32'h99, 5'd12);
    expBubbles = 2;
    expectOut("flushOverStall", 0, 5'b00000, 0, 0, 32'h88, 32'h77, 32'h99, 5'd12, 1);

    // Ten stalls: dutB's 3-bit counter sticks at 7.
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 1, 0, 1, 5'b11111, 1, 32'h5, 32'h6, 32'h7, 5'd8);
      expStalls = 3 + i;
      expectOut("stallSaturate", 0, 5'b00000, 0, 0, 32'h88, 32'h77, 32'h99, 5'd12, 1);
    end

    // Invalid slot with every control bit set must load no control.
    applyStimulus(0, 0, 0, 0, 5'b11111, 0, 32'h1, 32'h2, 32'h3, 5'd5);
    expBubbles = 3;
    expectOut("invalidMask", 0, 5'b00000, 0, 0, 32'h1, 32'h2, 32'h3, 5'd5, 0);

    applyStimulus(0, 0, 0, 1, 5'b00000, 0, 32'h0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
